// File: rtl/instr_encoder_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder_if
// Purpose  : control-bundle handshake, serial output and status bus
// Revision : 1.0
// ============================================================================
interface instr_encoder_if;
  logic       in_valid;
  logic       in_ready;
  logic       bez;
  logic       ja;
  logic       op1;
  logic       op2;
  logic       writeReg;
  logic       writex8;
  logic [1:0] x8Sel;
  logic [4:0] operand;
  logic       ser_out;
  logic       ser_frame;
  logic       err;
  logic [7:0] tx_count;

  modport master (
    output in_valid, bez, ja, op1, op2, writeReg, writex8, x8Sel, operand,
    input  in_ready, ser_out, ser_frame, err, tx_count
  );

  modport slave (
    input  in_valid, bez, ja, op1, op2, writeReg, writex8, x8Sel, operand,
    output in_ready, ser_out, ser_frame, err, tx_count
  );
endinterface
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder
// Purpose  : encodes CPU control bundles into 8-bit words, queues them in a
//            2-entry FIFO and shifts them out MSB first with idle gaps
// Revision : 1.0
// ============================================================================
module instr_encoder #(
  parameter int GAP_CYCLES = 1
) (
  input  logic           clk,
  input  logic           reset,
  instr_encoder_if.slave bus
);

  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [7:0] w_ctl;
  logic       w_legal;
  logic [2:0] w_opcode;
  logic       w_take;
  logic       w_push;
  logic       w_pop;
  logic       w_frame;
  logic       w_bit;

  logic [7:0] r_mem [2];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;
  logic       r_err;
  logic [7:0] r_shift;
  logic [2:0] r_idx;
  logic [3:0] r_gap;
  logic [7:0] r_tx_count;

  // Packed as {bez, ja, op1, op2, writeReg, writex8, x8Sel}; only the seven
  // decode patterns are legal, everything else is dropped with an err pulse.
  assign w_ctl = {bus.bez, bus.ja, bus.op1, bus.op2, bus.writeReg, bus.writex8, bus.x8Sel};

  always_comb begin
    w_legal  = 1'b1;
    w_opcode = 3'b000;
    case (w_ctl)
      8'h05:   w_opcode = 3'b001;
      8'h70:   w_opcode = 3'b100;
      8'h90:   w_opcode = 3'b000;
      8'h26:   w_opcode = 3'b011;
      8'h04:   w_opcode = 3'b101;
      8'h27:   w_opcode = 3'b111;
      8'h08:   w_opcode = 3'b110;
      default: w_legal  = 1'b0;
    endcase
  end

  assign bus.in_ready = !reset && (r_count < 2'd2);
  assign w_take       = bus.in_valid && bus.in_ready;
  assign w_push       = w_take && w_legal;
  assign w_pop        = (r_state == S_IDLE) && (r_count != 2'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
      r_err    <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= {w_opcode, bus.operand};
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      r_err   <= w_take && !w_legal;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_frame = 1'b0;
    w_bit   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_count != 2'd0) w_next = S_SHIFT;
      end
      S_SHIFT: begin
        w_frame = 1'b1;
        w_bit   = r_shift[r_idx];
        if (r_idx == 3'd0) w_next = S_GAP;
      end
      S_GAP: begin
        if (r_gap == 4'd0) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift    <= 8'd0;
      r_idx      <= 3'd0;
      r_gap      <= 4'd0;
      r_tx_count <= 8'd0;
    end else if (w_pop) begin
      r_shift <= r_mem[r_rd_ptr];
      r_idx   <= 3'd7;
    end else if (r_state == S_SHIFT) begin
      r_idx <= r_idx - 3'd1;
      if (r_idx == 3'd0) begin
        r_gap      <= GAP_LAST;
        r_tx_count <= r_tx_count + 8'd1;
      end
    end else if ((r_state == S_GAP) && (r_gap != 4'd0)) begin
      r_gap <= r_gap - 4'd1;
    end
  end

  assign bus.ser_frame = w_frame;
  assign bus.ser_out   = w_bit;
  assign bus.err       = r_err;
  assign bus.tx_count  = r_tx_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// tb_instr_encoder: table of single bundles plus hand-written multi-cycle
// sequences (latency, back-to-back, reset abort) and a scoreboarded random run.
module tb_instr_encoder;
  localparam int GAP = 1;
  localparam int NV  = 12;

  typedef struct {
    logic [7:0] ctl;
    logic [4:0] opnd;
    logic       legal;
    logic [7:0] word;
    string      name;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  instr_encoder_if bus();
  instr_encoder #(.GAP_CYCLES(GAP)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Serial monitor: rebuilds words, counts err cycles, low-run lengths and idle violations.
  logic [7:0] got_q[$];
  int         gaps_q[$];
  int         frames = 0, err_pulses = 0, idle_viol = 0, low_run = 0, nbits = 0;
  logic [7:0] cur = 8'h00;

  always @(negedge clk) begin
    if (bus.err === 1'b1) err_pulses++;
    if (bus.ser_frame === 1'b1) begin
      if (nbits == 0) gaps_q.push_back(low_run);
      low_run = 0;
      cur = {cur[6:0], bus.ser_out};
      nbits++;
      if (nbits == 8) begin
        got_q.push_back(cur);
        frames++;
        nbits = 0;
      end
    end else begin
      nbits = 0;
      low_run++;
      if (bus.ser_out !== 1'b0) idle_viol++;
    end
  end

  // Reference encoding: {legal, opcode}
  function automatic logic [3:0] model(input logic [7:0] ctl);
    case (ctl)
      8'h05:   return 4'b1001;
      8'h70:   return 4'b1100;
      8'h90:   return 4'b1000;
      8'h26:   return 4'b1011;
      8'h04:   return 4'b1101;
      8'h27:   return 4'b1111;
      8'h08:   return 4'b1110;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic vec_t mk(input logic [7:0] ctl, input logic [4:0] opnd,
                              input logic legal, input logic [7:0] word, input string name);
    vec_t v;
    v.ctl = ctl; v.opnd = opnd; v.legal = legal; v.word = word; v.name = name;
    return v;
  endfunction

  task automatic drive(input logic [7:0] ctl, input logic [4:0] opnd, input logic v);
    {bus.bez, bus.ja, bus.op1, bus.op2, bus.writeReg, bus.writex8, bus.x8Sel} = ctl;
    bus.operand  = opnd;
    bus.in_valid = v;
  endtask

  // Called at a negedge; returns at the negedge after the transfer edge.
  task automatic send(input logic [7:0] ctl, input logic [4:0] opnd);
    int n;
    n = 0;
    drive(ctl, opnd, 1'b1);
    while (bus.in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("ready_timeout", 0, 1);
    @(negedge clk);
    drive(8'h00, 5'h00, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t       vecs[NV];
  logic [7:0] legal_ctl[7];

  initial begin
    int         tx0, f0, g0, n0, e0, n, low, hi, accepted, ill_hs, bad;
    logic [7:0] bits, ctl, w;
    logic [4:0] opnd;
    logic [3:0] m;
    logic       v, is_legal;
    logic [7:0] exp_q[$];

    vecs[0]  = mk(8'h05, 5'h15, 1'b1, 8'h35, "li");
    vecs[1]  = mk(8'h70, 5'h01, 1'b1, 8'h81, "ja");
    vecs[2]  = mk(8'h90, 5'h1F, 1'b1, 8'h1F, "bez");
    vecs[3]  = mk(8'h26, 5'h02, 1'b1, 8'h62, "add");
    vecs[4]  = mk(8'h04, 5'h0A, 1'b1, 8'hAA, "lr");
    vecs[5]  = mk(8'h27, 5'h10, 1'b1, 8'hF0, "not");
    vecs[6]  = mk(8'h08, 5'h03, 1'b1, 8'hC3, "sr");
    vecs[7]  = mk(8'h00, 5'h00, 1'b0, 8'h00, "all_zero");
    vecs[8]  = mk(8'hC0, 5'h04, 1'b0, 8'h00, "bez_ja");
    vecs[9]  = mk(8'h06, 5'h07, 1'b0, 8'h00, "sel2_no_op1");
    vecs[10] = mk(8'h25, 5'h00, 1'b0, 8'h00, "op1_sel1");
    vecs[11] = mk(8'hFF, 5'h1F, 1'b0, 8'h00, "all_ones");
    legal_ctl = '{8'h05, 8'h70, 8'h90, 8'h26, 8'h04, 8'h27, 8'h08};

    // Reset state
    reset = 1'b1;
    drive(8'h00, 5'h00, 1'b0);
    repeat (3) @(negedge clk);
    check("ready_in_reset", int'(bus.in_ready), 0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", int'(bus.in_ready), 1);
    check("rst_ser_frame", int'(bus.ser_frame), 0);
    check("rst_ser_out", int'(bus.ser_out), 0);
    check("rst_err", int'(bus.err), 0);
    check("rst_tx_count", int'(bus.tx_count), 0);

    // li / 0x15 latency and bit order
    send(8'h05, 5'h15);
    check("lat_frame_T1", int'(bus.ser_frame), 0);
    hi = 0;
    bits = 8'h00;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bits = {bits[6:0], bus.ser_out};
      if (bus.ser_frame === 1'b1) hi++;
    end
    check("lat_bits", int'(bits), 8'h35);
    check("lat_frame_high", hi, 8);
    @(negedge clk);
    check("lat_frame_end", int'(bus.ser_frame), 0);
    check("lat_tx_count", int'(bus.tx_count), 1);
    repeat (GAP + 4) @(negedge clk);

    // Single-bundle table
    for (int i = 0; i < NV; i++) begin
      tx0 = int'(bus.tx_count);
      f0  = frames;
      send(vecs[i].ctl, vecs[i].opnd);
      check({vecs[i].name, "_err"}, int'(bus.err), int'(!vecs[i].legal));
      @(negedge clk);
      check({vecs[i].name, "_err_single"}, int'(bus.err), 0);
      repeat (12 + GAP) @(negedge clk);
      check({vecs[i].name, "_frames"}, frames - f0, int'(vecs[i].legal));
      check({vecs[i].name, "_tx"}, int'(bus.tx_count), (tx0 + int'(vecs[i].legal)) % 256);
      if (vecs[i].legal && got_q.size() > 0)
        check({vecs[i].name, "_word"}, int'(got_q[got_q.size()-1]), int'(vecs[i].word));
    end

    // Back-to-back ja, add, sr
    tx0 = int'(bus.tx_count);
    g0  = got_q.size();
    n0  = gaps_q.size();
    drive(8'h70, 5'h01, 1'b1);
    check("b2b_ready0", int'(bus.in_ready), 1);
    @(negedge clk);
    drive(8'h26, 5'h02, 1'b1);
    check("b2b_ready1", int'(bus.in_ready), 1);
    @(negedge clk);
    drive(8'h08, 5'h03, 1'b1);
    check("b2b_ready2", int'(bus.in_ready), 1);
    @(negedge clk);
    drive(8'h00, 5'h00, 1'b0);
    low = 0;
    while (bus.in_ready !== 1'b1 && low < 100) begin
      low++;
      @(negedge clk);
    end
    // Head frame: 8 SHIFT cycles and GAP; the pop in IDLE frees the slot
    check("b2b_ready_low", low, 8 + GAP);
    repeat (40) @(negedge clk);
    check("b2b_count", got_q.size() - g0, 3);
    if (got_q.size() >= g0 + 3) begin
      check("b2b_word0", int'(got_q[g0]), 8'h81);
      check("b2b_word1", int'(got_q[g0+1]), 8'h62);
      check("b2b_word2", int'(got_q[g0+2]), 8'hC3);
    end
    // Low run between frames: GAP cycles plus the IDLE pop cycle
    if (gaps_q.size() >= n0 + 3) begin
      check("b2b_gap1", gaps_q[n0+1], GAP + 1);
      check("b2b_gap2", gaps_q[n0+2], GAP + 1);
    end
    check("b2b_tx", int'(bus.tx_count), (tx0 + 3) % 256);

    // Reset at the 4th bit with one entry still queued
    send(8'h05, 5'h15);
    drive(8'h04, 5'h0A, 1'b1);
    @(negedge clk);
    drive(8'h00, 5'h00, 1'b0);
    repeat (3) @(negedge clk);
    check("abort_pre_frame", int'(bus.ser_frame), 1);
    f0 = frames;
    reset = 1'b1;
    @(negedge clk);
    check("abort_frame", int'(bus.ser_frame), 0);
    check("abort_ready_in_reset", int'(bus.in_ready), 0);
    check("abort_tx", int'(bus.tx_count), 0);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("abort_no_frames", frames - f0, 0);
    check("abort_tx_after", int'(bus.tx_count), 0);
    check("abort_ready_after", int'(bus.in_ready), 1);

    // Random legal/illegal with random in_valid, until 256 legal words taken
    g0 = got_q.size();
    e0 = err_pulses;
    accepted = 0;
    ill_hs = 0;
    n = 0;
    while (accepted < 256 && n < 20000) begin
      if ($urandom_range(0, 3) == 0) begin
        do begin
          ctl = 8'($urandom);
          m = model(ctl);
        end while (m[3]);
      end else begin
        ctl = legal_ctl[$urandom_range(0, 6)];
      end
      opnd = 5'($urandom);
      v = 1'($urandom_range(0, 1));
      drive(ctl, opnd, v);
      m = model(ctl);
      is_legal = m[3];
      if (v && bus.in_ready === 1'b1) begin
        if (is_legal) begin
          exp_q.push_back({m[2:0], opnd});
          accepted++;
        end else begin
          ill_hs++;
        end
      end
      @(negedge clk);
      n++;
    end
    drive(8'h00, 5'h00, 1'b0);
    check("rand_accept_budget", accepted, 256);
    n = 0;
    while (got_q.size() - g0 < exp_q.size() && n < 2000) begin
      @(negedge clk);
      n++;
    end
    repeat (GAP + 4) @(negedge clk);
    check("rand_frame_count", got_q.size() - g0, exp_q.size());
    bad = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (g0 + i < got_q.size()) begin
        w = got_q[g0+i];
        if (w !== exp_q[i]) bad++;
      end
    end
    check("rand_order_content", bad, 0);
    check("rand_err_pulses", err_pulses - e0, ill_hs);
    check("wrap_tx_count", int'(bus.tx_count), 0);
    check("idle_ser_out_zero", idle_viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
